// File: rtl/nx_ctrl_byte_bridge_pkg.sv
// Shared definitions for the nx_control host byte bridge.
package nx_ctrl_byte_bridge_pkg;

    localparam int unsigned NX_MESSAGE_WIDTH = 32;

    typedef logic [NX_MESSAGE_WIDTH-1:0] nx_ctrl_req_t;
    typedef logic [NX_MESSAGE_WIDTH-1:0] nx_ctrl_resp_t;

    typedef enum logic {
        NX_BRIDGE_IDLE,
        NX_BRIDGE_SEND
    } nx_bridge_tx_state_t;

    function automatic int unsigned nx_bytes_per_msg(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/nx_ctrl_byte_bridge_serialiser.sv
// Response serialiser: latches one response word and emits it MSB byte first.
module nx_byte_serialiser
    import nx_ctrl_byte_bridge_pkg::*;
#(
    parameter int unsigned MSG_WIDTH = NX_MESSAGE_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [MSG_WIDTH-1:0] i_word,
    input  logic                 i_word_valid,
    output logic                 o_word_ready,
    output logic [7:0]           o_byte,
    output logic                 o_byte_valid,
    input  logic                 i_byte_ready
);

    localparam int unsigned NB = nx_bytes_per_msg(MSG_WIDTH);
    localparam int unsigned CW = $clog2(NB) + 1;

    nx_bridge_tx_state_t  r_state;
    logic [MSG_WIDTH-1:0] r_word;
    logic [CW-1:0]        r_count;
    logic                 r_ready;
    logic                 r_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= NX_BRIDGE_IDLE;
            r_word  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                NX_BRIDGE_IDLE: begin
                    if (r_ready && i_word_valid) begin
                        r_word  <= i_word;
                        r_count <= '0;
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= NX_BRIDGE_SEND;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                NX_BRIDGE_SEND: begin
                    if (i_byte_ready) begin
                        r_word  <= r_word << 8;
                        r_count <= r_count + 1'b1;
                        // Last byte: ready rises the cycle after it leaves
                        if (r_count == CW'(NB - 1)) begin
                            r_valid <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= NX_BRIDGE_IDLE;
                        end
                    end
                end
                default: r_state <= NX_BRIDGE_IDLE;
            endcase
        end
    end

    assign o_word_ready = r_ready;
    assign o_byte_valid = r_valid;
    assign o_byte       = r_word[MSG_WIDTH-1 -: 8];

endmodule

// File: rtl/nx_ctrl_byte_bridge.sv
// Host framing stage for nx_control: byte-to-request assembly with stale-frame
// timeout, and response-to-byte serialisation.
module nx_ctrl_byte_bridge
    import nx_ctrl_byte_bridge_pkg::*;
#(
    parameter int unsigned MSG_WIDTH = NX_MESSAGE_WIDTH,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [7:0]           host_rx_data_i,
    input  logic                 host_rx_valid_i,
    output logic                 host_rx_ready_o,
    output logic [7:0]           host_tx_data_o,
    output logic                 host_tx_valid_o,
    input  logic                 host_tx_ready_i,
    output logic [MSG_WIDTH-1:0] req_data_o,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    input  logic [MSG_WIDTH-1:0] resp_data_i,
    input  logic                 resp_valid_i,
    output logic                 resp_ready_o,
    output logic                 frame_drop_o
);

    localparam int unsigned NB = nx_bytes_per_msg(MSG_WIDTH);
    localparam int unsigned CW = $clog2(NB) + 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [MSG_WIDTH-1:0] r_shift;
    logic [CW-1:0]        r_rx_count;
    logic [TW-1:0]        r_to_cnt;
    logic                 r_req_valid;
    logic                 r_rx_ready;
    logic                 r_drop;
    logic                 w_rx_acc;

    assign w_rx_acc = host_rx_valid_i && r_rx_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shift     <= '0;
            r_rx_count  <= '0;
            r_to_cnt    <= '0;
            r_req_valid <= 1'b0;
            r_rx_ready  <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_drop <= 1'b0;

            // Registered copy of !req_valid so the ready output is 0 in reset
            if (r_req_valid) begin
                if (req_ready_i) begin
                    r_req_valid <= 1'b0;
                    r_rx_ready  <= 1'b1;
                end
            end else begin
                r_rx_ready <= 1'b1;
            end

            if (w_rx_acc) begin
                r_shift  <= {r_shift[MSG_WIDTH-9:0], host_rx_data_i};
                r_to_cnt <= '0;
                if (r_rx_count == CW'(NB - 1)) begin
                    r_rx_count  <= '0;
                    r_req_valid <= 1'b1;
                    r_rx_ready  <= 1'b0;
                end else begin
                    r_rx_count <= r_rx_count + 1'b1;
                end
            end else if (r_rx_count == '0) begin
                r_to_cnt <= '0;
            end else if (TIMEOUT != 0) begin
                // Expiry lands on the TIMEOUT-th idle cycle; counter never passes it
                if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                    r_rx_count <= '0;
                    r_shift    <= '0;
                    r_to_cnt   <= '0;
                    r_drop     <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    assign host_rx_ready_o = r_rx_ready;
    assign req_valid_o     = r_req_valid;
    assign req_data_o      = r_shift;
    assign frame_drop_o    = r_drop;

    nx_byte_serialiser #(
        .MSG_WIDTH (MSG_WIDTH)
    ) u_tx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_word       (resp_data_i),
        .i_word_valid (resp_valid_i),
        .o_word_ready (resp_ready_o),
        .o_byte       (host_tx_data_o),
        .o_byte_valid (host_tx_valid_o),
        .i_byte_ready (host_tx_ready_i)
    );

endmodule

// File: tb/tb_nx_ctrl_byte_bridge.sv
// Self-checking bench for nx_ctrl_byte_bridge: queue-based frame model plus
// directed literal checks and a randomized phase.
module tb_nx_ctrl_byte_bridge;

    localparam int unsigned MW = 32;
    localparam int unsigned NB = 4;
    localparam int unsigned TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [7:0]    host_rx_data_i;
    logic          host_rx_valid_i;
    logic          host_rx_ready_o;
    logic [7:0]    host_tx_data_o;
    logic          host_tx_valid_o;
    logic          host_tx_ready_i;
    logic [MW-1:0] req_data_o;
    logic          req_valid_o;
    logic          req_ready_i;
    logic [MW-1:0] resp_data_i;
    logic          resp_valid_i;
    logic          resp_ready_o;
    logic          frame_drop_o;

    always #5 clk_i = ~clk_i;

    nx_ctrl_byte_bridge #(
        .MSG_WIDTH (MW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .host_rx_data_i  (host_rx_data_i),
        .host_rx_valid_i (host_rx_valid_i),
        .host_rx_ready_o (host_rx_ready_o),
        .host_tx_data_o  (host_tx_data_o),
        .host_tx_valid_o (host_tx_valid_o),
        .host_tx_ready_i (host_tx_ready_i),
        .req_data_o      (req_data_o),
        .req_valid_o     (req_valid_o),
        .req_ready_i     (req_ready_i),
        .resp_data_i     (resp_data_i),
        .resp_valid_i    (resp_valid_i),
        .resp_ready_o    (resp_ready_o),
        .frame_drop_o    (frame_drop_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_drops = 0;

    // Behavioural model: partial frame and pending TX bytes as queues
    logic [7:0]    m_partial[$];
    logic [7:0]    m_txq[$];
    logic [MW-1:0] m_req_data;
    bit            m_req_valid, m_rx_ready, m_resp_ready, m_drop;
    int            m_idle;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_partial.delete();
        m_txq.delete();
        m_req_data   = '0;
        m_req_valid  = 1'b0;
        m_rx_ready   = 1'b0;
        m_resp_ready = 1'b0;
        m_drop       = 1'b0;
        m_idle       = 0;
    endtask

    task automatic compare_all();
        check("rx_ready", host_rx_ready_o, m_rx_ready);
        check("req_valid", req_valid_o, m_req_valid);
        if (m_req_valid) check("req_data", req_data_o, m_req_data);
        check("frame_drop", frame_drop_o, m_drop);
        check("tx_valid", host_tx_valid_o, m_txq.size() != 0);
        if (m_txq.size() != 0) check("tx_data", host_tx_data_o, m_txq[0]);
        check("resp_ready", resp_ready_o, m_resp_ready);
    endtask

    // Advance model and DUT one clock, then compare on the falling edge
    task automatic tick();
        bit rx_acc, req_xfer, resp_acc, tx_xfer;
        rx_acc   = host_rx_valid_i && m_rx_ready;
        req_xfer = m_req_valid && req_ready_i;
        resp_acc = resp_valid_i && m_resp_ready;
        tx_xfer  = (m_txq.size() != 0) && host_tx_ready_i;
        if (rst_i) begin
            model_reset();
        end else begin
            m_drop = 1'b0;
            if (req_xfer) m_req_valid = 1'b0;
            if (rx_acc) begin
                m_partial.push_back(host_rx_data_i);
                m_idle = 0;
                if (m_partial.size() == NB) begin
                    m_req_data = '0;
                    for (int i = 0; i < NB; i++)
                        m_req_data = m_req_data | (MW'(m_partial[i]) << (8 * (NB - 1 - i)));
                    m_req_valid = 1'b1;
                    m_partial.delete();
                end
            end else if (m_partial.size() != 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_partial.delete();
                    m_idle = 0;
                    m_drop = 1'b1;
                end
            end else begin
                m_idle = 0;
            end
            m_rx_ready = !m_req_valid;
            if (tx_xfer) void'(m_txq.pop_front());
            if (resp_acc)
                for (int i = NB - 1; i >= 0; i--) m_txq.push_back(resp_data_i[i*8 +: 8]);
            m_resp_ready = (m_txq.size() == 0);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all();
        if (frame_drop_o === 1'b1) n_drops++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done = 1'b0;
        host_rx_valid_i = 1'b1;
        host_rx_data_i  = b;
        for (int c = 0; c < 50 && !done; c++) begin
            done = m_rx_ready;
            tick();
        end
        check("rx_accept_bound", done, 1'b1);
        host_rx_valid_i = 1'b0;
    endtask

    task automatic send_resp(input logic [MW-1:0] w);
        bit done;
        done = 1'b0;
        resp_valid_i = 1'b1;
        resp_data_i  = w;
        for (int c = 0; c < 50 && !done; c++) begin
            done = m_resp_ready;
            tick();
        end
        check("resp_accept_bound", done, 1'b1);
        resp_valid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [MW-1:0] w);
        for (int i = NB - 1; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_ready"}, host_rx_ready_o, 0);
        check({tag, "_req_valid"}, req_valid_o, 0);
        check({tag, "_req_data"}, req_data_o, 0);
        check({tag, "_tx_valid"}, host_tx_valid_o, 0);
        check({tag, "_tx_data"}, host_tx_data_o, 0);
        check({tag, "_resp_ready"}, resp_ready_o, 0);
        check({tag, "_drop"}, frame_drop_o, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            d0, k, c;
        logic [7:0]    got[$];
        logic [7:0]    rxq[$];
        logic [MW-1:0] exp_tx;
        bit            tg, resp_done, ra, pa, acc;

        rst_i = 1'b1; host_rx_data_i = '0; host_rx_valid_i = 1'b0; host_tx_ready_i = 1'b0;
        req_ready_i = 1'b0; resp_data_i = '0; resp_valid_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        check_all_zero("reset");
        tick();
        rst_i = 1'b0;
        tick();

        // Basic frame, consumer always ready
        req_ready_i = 1'b1;
        d0 = n_drops;
        send_frame(32'h01020304);
        check("t1_req_valid", req_valid_o, 1);
        check("t1_req_data", req_data_o, 32'h01020304);
        check("t1_model_data", m_req_data, 32'h01020304);
        tick();
        check("t1_req_cleared", req_valid_o, 0);
        check("t1_no_drop", n_drops, d0);

        // Backpressure: request held 10 cycles, 5th byte waits
        req_ready_i = 1'b0;
        send_frame(32'h01020304);
        host_rx_valid_i = 1'b1;
        host_rx_data_i  = 8'h55;
        repeat (10) begin
            tick();
            check("t2_hold_valid", req_valid_o, 1);
            check("t2_hold_data", req_data_o, 32'h01020304);
            check("t2_rx_ready_low", host_rx_ready_o, 0);
        end
        req_ready_i = 1'b1;
        acc = 1'b0;
        c = 0;
        while (!acc && c < 10) begin
            acc = m_rx_ready;
            tick();
            c++;
        end
        check("t2_accept_latency", c, 2);
        host_rx_valid_i = 1'b0;
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h88);
        check("t2_next_frame", req_data_o, 32'h55667788);
        tick();

        // Timeout drops a stale partial frame after 16 idle cycles
        send_byte(8'hAA);
        send_byte(8'hBB);
        d0 = n_drops;
        k = 0;
        while (n_drops == d0 && k < 40) begin
            tick();
            k++;
        end
        check("t3_drop_after", k, 16);
        send_frame(32'h11223344);
        check("t3_clean_frame", req_data_o, 32'h11223344);
        tick();

        // Byte arriving on the expiry cycle wins
        d0 = n_drops;
        send_byte(8'hCC);
        repeat (15) tick();
        send_byte(8'hDD);
        check("t3b_no_drop_pulse", frame_drop_o, 0);
        send_byte(8'hEE);
        send_byte(8'hFF);
        check("t3b_frame", req_data_o, 32'hCCDDEEFF);
        check("t3b_no_drops", n_drops, d0);
        tick();

        // TX with host ready toggling
        host_tx_ready_i = 1'b0;
        send_resp(32'hDEADBEEF);
        got.delete();
        tg = 1'b0;
        c  = 0;
        while (got.size() < NB && c < 40) begin
            host_tx_ready_i = tg;
            check("t4_resp_ready_low", resp_ready_o, 0);
            if (host_tx_valid_o && tg) got.push_back(host_tx_data_o);
            tick();
            tg = !tg;
            c++;
        end
        host_tx_ready_i = 1'b0;
        exp_tx = 32'hDEADBEEF;
        check("t4_byte_count", got.size(), NB);
        for (int i = 0; i < NB && i < got.size(); i++)
            check("t4_tx_byte", got[i], exp_tx[8*(NB-1-i) +: 8]);
        check("t4_resp_ready_after", resp_ready_o, 1);

        // Concurrent RX frame and TX response
        rxq = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
        got.delete();
        resp_done = 1'b0;
        req_ready_i = 1'b0;
        host_tx_ready_i = 1'b1;
        resp_data_i = 32'h12345678;
        c = 0;
        while ((rxq.size() != 0 || got.size() < NB) && c < 20) begin
            host_rx_valid_i = (rxq.size() != 0);
            host_rx_data_i  = (rxq.size() != 0) ? rxq[0] : 8'h00;
            resp_valid_i    = !resp_done;
            ra = host_rx_valid_i && m_rx_ready;
            pa = resp_valid_i && m_resp_ready;
            if (host_tx_valid_o && host_tx_ready_i) got.push_back(host_tx_data_o);
            tick();
            c++;
            if (ra) begin
                void'(rxq.pop_front());
                if (rxq.size() == 0) begin
                    check("t5_req_valid", req_valid_o, 1);
                    check("t5_req_data", req_data_o, 32'h9ABCDEF0);
                end
            end
            if (pa) resp_done = 1'b1;
        end
        host_rx_valid_i = 1'b0;
        resp_valid_i    = 1'b0;
        host_tx_ready_i = 1'b0;
        check("t5_cycles", c, 5);
        exp_tx = 32'h12345678;
        for (int i = 0; i < NB && i < got.size(); i++)
            check("t5_tx_byte", got[i], exp_tx[8*(NB-1-i) +: 8]);
        req_ready_i = 1'b1;
        tick();

        // Randomized traffic on both paths
        k = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!host_rx_valid_i && k == 0 && $urandom_range(0, 199) == 0) k = 25;
            if (k > 0) k--;
            if (!host_rx_valid_i && k == 0 && $urandom_range(0, 99) < 70) begin
                host_rx_valid_i = 1'b1;
                host_rx_data_i  = 8'($urandom);
            end
            if (!resp_valid_i && $urandom_range(0, 99) < 30) begin
                resp_valid_i = 1'b1;
                resp_data_i  = $urandom;
            end
            req_ready_i     = ($urandom_range(0, 99) < 60);
            host_tx_ready_i = ($urandom_range(0, 99) < 60);
            ra = host_rx_valid_i && m_rx_ready;
            pa = resp_valid_i && m_resp_ready;
            tick();
            if (ra) host_rx_valid_i = 1'b0;
            if (pa) resp_valid_i = 1'b0;
        end
        host_rx_valid_i = 1'b0;
        resp_valid_i    = 1'b0;
        req_ready_i     = 1'b1;
        repeat (NB + 2) tick();
        host_tx_ready_i = 1'b1;
        repeat (NB + 2) tick();

        // Reset mid RX frame and mid TX byte 2
        send_byte(8'h01);
        send_byte(8'h02);
        host_tx_ready_i = 1'b0;
        send_resp(32'hA5C3E1F7);
        host_tx_ready_i = 1'b1;
        tick();
        host_tx_ready_i = 1'b0;
        tick();
        check("t6_second_byte", host_tx_data_o, 8'hC3);
        rst_i = 1'b1;
        #1;
        check_all_zero("t6_async_rst");
        model_reset();
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        send_frame(32'hCAFEF00D);
        check("t6_fresh_frame", req_data_o, 32'hCAFEF00D);
        tick();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
